alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Each requester issues a command (opcode, operands, flag) over a valid/ready handshake.
- The controller registers the winning command, drives the ALU inputs, captures result and C/Z flags, and returns them over a response handshake tagged with the requester ID.
- Keeps a per-requester saved carry so a requester can chain multi-word operations.
- Sits between the lab datapath front-ends and the ALU instance.

Parameters:
- N, 4, operand/result width; must match the ALU width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- req_valid  in  2  per-requester command valid, bit i = requester i
- req_ready  out  2  per-requester command accepted this cycle (at most one bit high)
- req_op0, req_op1  in  4  opcode, ALU encoding 0x0..0x9
- req_a0, req_a1  in  N  operand A
- req_b0, req_b1  in  N  operand B
- req_flag0, req_flag1  in  1  flag input to the ALU when not chaining
- req_chain  in  2  1 = use that requester's saved carry as the ALU flag input
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued this response
- rsp_result  out  N  ALU result
- rsp_c, rsp_z  out  1  ALU carry / zero flags
- rsp_err  out  1  illegal opcode (0xA..0xF)
- alu_a, alu_b  out  N  to ALU operand inputs
- alu_ctrl  out  4  to ALU control input
- alu_flag_in  out  1  to ALU flag input
- alu_result  in  N  from ALU
- alu_c, alu_z  in  1  from ALU

Behaviour:
- Clock: single clock domain.
- Reset: reset is synchronous and active-low (rst_n sampled on rising clk). On reset:
  - state = IDLE, rsp_valid = 0, req_ready = 0
  - rsp_id/result/c/z/err = 0
  - alu_a/alu_b/alu_ctrl/alu_flag_in = 0
  - saved carry[1:0] = 0, round-robin pointer = 0 (port 0 favoured)
  - Reset mid-operation discards any in-flight command and response.
- FSM, IDLE:
  - req_ready is combinational and asserted only in IDLE, for the arbitration winner.
  - If exactly one requester is valid, it wins.
  - If both are valid, the pointer's port wins; the pointer then flips to the other port.
  - The pointer changes only on an accepted command.
  - On accept, latch op/a/b/id and the effective flag: chain ? saved carry[id] : req_flag.
  - Legal op -> EXEC. Illegal op -> RESP with err=1, result=0, c=0, z=0; ALU not driven with new values.
- FSM, EXEC (one cycle):
  - alu_* driven from the latched registers and held stable for the whole cycle.
  - At the end of the cycle, capture alu_result/alu_c/alu_z into the rsp registers, write saved carry[id] = alu_c, set err = 0, go to RESP.
- FSM, RESP:
  - rsp_valid = 1; outputs held stable until rsp_valid & rsp_ready, then -> IDLE.
  - No new command is accepted in RESP, so back-to-back throughput is one op per 3 cycles.
- alu_* outputs keep their last values outside EXEC.
- Latency: handshake at cycle T -> rsp_valid at T+2 (legal) or T+1 (illegal). rsp_ready may already be high, in which case RESP lasts one cycle.
- Saved carry updates only on legal ops, and only for the issuing requester.
- Requester behaviour on deassert: a requester dropping req_valid before being accepted is simply not served; no state is kept for it.
- Width rules:
  - All operands are N bits; no extension in the controller.
  - Carry semantics are entirely the ALU's; the controller forwards alu_c unchanged.

Decomposition:
- Shared package (alu_pkg):
  - opcode localparams OP_AND=0x0, OP_OR=0x1, OP_ADD=0x2, OP_INC=0x3, OP_DEC=0x4, OP_NOT=0x5, OP_SUB=0x6, OP_XOR=0x7, OP_SHL=0x8, OP_SHR=0x9, OP_MAX_LEGAL=0x9
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP
- One sub-module: rr_arb2, a 2-way round-robin grant with a pointer update on accept.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
1. Reset then single request: port0 op=0x2, a=4'h5, b=4'h3, flag=0 -> rsp_valid at T+2, result=4'h8, c=0, z=0, id=0, err=0.
2. Contention: both ports valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and each response id matches its grant.
3. Carry chain: port1 ADD a=4'hF, b=4'h1 -> result=0, z=1, c=1 (the ALU's reported carry). Next port1 ADD a=0, b=0, chain=1 -> alu_flag_in=1, result=4'h1.
4. Illegal opcode: port0 op=0xB -> rsp_valid at T+1, err=1, result=0; alu_* unchanged; saved carry unchanged.
5. Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout. Raising rsp_ready completes the response and returns to IDLE.
6. rst_n=0 for one cycle during EXEC -> next cycle rsp_valid=0, state IDLE, saved carries 0, and the pending command is never responded to.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, controller
// state type and an opcode legality helper.
package alu_pkg;

   localparam logic [3:0] OP_AND       = 4'h0;
   localparam logic [3:0] OP_OR        = 4'h1;
   localparam logic [3:0] OP_ADD       = 4'h2;
   localparam logic [3:0] OP_INC       = 4'h3;
   localparam logic [3:0] OP_DEC       = 4'h4;
   localparam logic [3:0] OP_NOT       = 4'h5;
   localparam logic [3:0] OP_SUB       = 4'h6;
   localparam logic [3:0] OP_XOR       = 4'h7;
   localparam logic [3:0] OP_SHL       = 4'h8;
   localparam logic [3:0] OP_SHR       = 4'h9;
   localparam logic [3:0] OP_MAX_LEGAL = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_MAX_LEGAL;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured port when
// both request; after an accepted grant it moves to the other port than
// the one just served.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       id
);

   logic ptr;

   // Winner selection; grants are only issued while enabled
   always_comb begin
      id  = 1'b0;
      gnt = '0;
      unique case (req)
         2'b01:   id = 1'b0;
         2'b10:   id = 1'b1;
         2'b11:   id = ptr;
         default: id = 1'b0;
      endcase
      if (en && (req != 2'b00)) begin
         gnt = id ? 2'b10 : 2'b01;
      end
   end

   // Pointer moves away from the served port on every accepted grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (gnt != 2'b00) begin
         ptr <= ~id;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. Accepts a
// command in IDLE, drives the ALU for one EXEC cycle, then holds the tagged
// response in RESP until consumed. Keeps a saved carry per requester for
// chained multi-word arithmetic.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [3:0]   req_op0,
   input  logic [3:0]   req_op1,
   input  logic [N-1:0] req_a0,
   input  logic [N-1:0] req_a1,
   input  logic [N-1:0] req_b0,
   input  logic [N-1:0] req_b1,
   input  logic         req_flag0,
   input  logic         req_flag1,
   input  logic [1:0]   req_chain,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic         rsp_c,
   output logic         rsp_z,
   output logic         rsp_err,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   output logic         alu_flag_in,
   input  logic [N-1:0] alu_result,
   input  logic         alu_c,
   input  logic         alu_z
);

   state_t       state, state_nx;
   logic [1:0]   saved_c;
   logic [1:0]   gnt;
   logic         sel_id;
   logic         accept;
   logic [3:0]   sel_op;
   logic [N-1:0] sel_a, sel_b;
   logic         sel_flag;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .en    (state == ST_IDLE),
      .gnt   (gnt),
      .id    (sel_id)
   );

   // Route the winner's command and resolve its effective flag
   always_comb begin
      req_ready = gnt;
      accept    = (gnt != 2'b00);
      sel_op    = sel_id ? req_op1 : req_op0;
      sel_a     = sel_id ? req_a1  : req_a0;
      sel_b     = sel_id ? req_b1  : req_b0;
      sel_flag  = req_chain[sel_id] ? saved_c[sel_id]
                                    : (sel_id ? req_flag1 : req_flag0);
   end

   // Controller state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and response-valid decode
   always_comb begin
      state_nx  = state;
      rsp_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = op_legal(sel_op) ? ST_EXEC : ST_RESP;
            end
         end
         ST_EXEC: state_nx = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // ALU operand registers double as the latched command, so they hold their
   // last values outside EXEC and are left alone by illegal commands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_ctrl    <= '0;
         alu_flag_in <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_c       <= 1'b0;
         rsp_z       <= 1'b0;
         rsp_err     <= 1'b0;
         saved_c     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  rsp_id <= sel_id;
                  if (op_legal(sel_op)) begin
                     alu_a       <= sel_a;
                     alu_b       <= sel_b;
                     alu_ctrl    <= sel_op;
                     alu_flag_in <= sel_flag;
                  end else begin
                     rsp_result <= '0;
                     rsp_c      <= 1'b0;
                     rsp_z      <= 1'b0;
                     rsp_err    <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               rsp_result      <= alu_result;
               rsp_c           <= alu_c;
               rsp_z           <= alu_z;
               rsp_err         <= 1'b0;
               saved_c[rsp_id] <= alu_c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [3:0] req_op0, req_op1;
   logic [3:0] req_a0, req_a1, req_b0, req_b1;
   logic       req_flag0, req_flag1;
   logic [1:0] req_chain;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [3:0] rsp_result;
   logic       rsp_c, rsp_z, rsp_err;
   logic [3:0] alu_a, alu_b, alu_ctrl;
   logic       alu_flag_in;
   logic [3:0] alu_result;
   logic       alu_c, alu_z;

   int vectors = 0;
   int miscompares = 0;

   alu_arbiter #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1),
      .req_flag0(req_flag0), .req_flag1(req_flag1),
      .req_chain(req_chain),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_flag_in(alu_flag_in),
      .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {c, z, result}
   function automatic logic [5:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic f);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      r = '0;
      c = 1'b0;
      s = '0;
      case (op)
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'h2: begin s = {1'b0, a} + {1'b0, b} + {4'b0, f}; r = s[3:0]; c = s[4]; end
         4'h3: begin s = {1'b0, a} + 5'd1; r = s[3:0]; c = s[4]; end
         4'h4: begin r = a - 4'd1; c = (a == 4'h0); end
         4'h5: r = ~a;
         4'h6: begin r = a - b; c = (a < b); end
         4'h7: r = a ^ b;
         4'h8: begin r = {a[2:0], 1'b0}; c = a[3]; end
         4'h9: begin r = {1'b0, a[3:1]}; c = a[0]; end
         default: ;
      endcase
      return {c, (r == 4'h0), r};
   endfunction

   always_comb {alu_c, alu_z, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b, alu_flag_in);

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       port;
      logic [3:0] op, a, b;
      logic       flag, chain;
      logic [3:0] result;
      logic       c, z, err;
      logic [3:0] ctrl;
      logic       fin;
      int         lat;
   } vec_t;

   vec_t tbl[10];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_result", {rsp_id, rsp_c, rsp_z, rsp_err, rsp_result}, 0);
      check("reset_alu", {alu_a, alu_b, alu_ctrl, alu_flag_in}, 0);
   endtask

   task automatic drive_cmd(input vec_t v);
      req_op0 = v.op; req_op1 = v.op;
      req_a0 = v.a;   req_a1 = v.a;
      req_b0 = v.b;   req_b1 = v.b;
      req_flag0 = v.flag; req_flag1 = v.flag;
      req_chain = {v.chain, v.chain};
      req_valid = v.port ? 2'b10 : 2'b01;
   endtask

   // Issue one command from idle with rsp_ready high and check the response
   task automatic run_vec(input vec_t v, input string tag);
      int n;
      @(negedge clk);
      rsp_ready = 1'b1;
      drive_cmd(v);
      #1;
      check({tag, "_ready"}, req_ready, v.port ? 2 : 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      n = 1;
      while (!rsp_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, v.lat);
      check({tag, "_id"}, rsp_id, v.port);
      check({tag, "_result"}, rsp_result, v.result);
      check({tag, "_cze"}, {rsp_c, rsp_z, rsp_err}, {v.c, v.z, v.err});
      check({tag, "_alu"}, {alu_ctrl, alu_flag_in}, {v.ctrl, v.fin});
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done"}, rsp_valid, 0);
   endtask

   // Randomized-phase transaction model
   logic       m_busy, m_ptr, m_id, win;
   int         m_cnt;
   logic [1:0] m_saved;
   logic [3:0] m_res, m_alu_a, m_alu_b, m_alu_ctrl;
   logic       m_c, m_z, m_err, m_alu_f;
   logic [1:0] exp_rdy;

   initial begin
      vec_t v;
      int   n;
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      req_flag0 = 1'b0; req_flag1 = 1'b0; req_chain = '0;

      //         port op    a     b     f     ch    res   c     z     err   ctrl  fin   lat
      tbl[0] = '{1'b0, 4'h2, 4'h5, 4'h3, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 2};
      tbl[1] = '{1'b1, 4'h2, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 2};
      tbl[2] = '{1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 2};
      tbl[3] = '{1'b0, 4'hB, 4'h7, 4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1};
      tbl[4] = '{1'b0, 4'h0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2};
      tbl[5] = '{1'b0, 4'h7, 4'h5, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 2};
      tbl[6] = '{1'b1, 4'h6, 4'h3, 4'h5, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 2};
      tbl[7] = '{1'b0, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1};
      tbl[8] = '{1'b1, 4'h8, 4'h9, 4'h0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h8, 1'b1, 2};
      tbl[9] = '{1'b0, 4'h4, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 2};

      do_reset();
      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Backpressure: response held stable, no grants while in RESP
      @(negedge clk);
      rsp_ready = 1'b0;
      v = '{1'b0, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 2};
      drive_cmd(v);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b11;
      n = 0;
      while (!rsp_valid && n < 8) begin @(negedge clk); n++; end
      check("bp_reached_resp", rsp_valid, 1);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_valid", rsp_valid, 1);
         check("bp_result", {rsp_id, rsp_err, rsp_result}, 5'h02);
         check("bp_ready", req_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      req_valid = 2'b01;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("bp_back_idle", {rsp_valid, req_ready}, 3'b001);
      req_valid = '0;

      // Reset during EXEC: pending command dropped, saved carries cleared
      run_vec('{1'b1, 4'h2, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 2}, "pre_rst");
      @(negedge clk);
      drive_cmd('{1'b1, 4'h2, 4'h3, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0});
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_exec_valid", rsp_valid, 0);
      check("rst_exec_alu", {alu_a, alu_b, alu_ctrl}, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_exec_no_rsp", rsp_valid, 0);
      end
      run_vec('{1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 2}, "post_rst_chain");

      // Contention from reset: grants alternate starting with port 0
      do_reset();
      @(negedge clk);
      rsp_ready = 1'b1;
      req_op0 = 4'h2; req_a0 = 4'h1; req_b0 = 4'h2; req_flag0 = 1'b0;
      req_op1 = 4'h7; req_a1 = 4'h6; req_b1 = 4'h3; req_flag1 = 1'b0;
      req_chain = '0;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         #1;
         while (req_ready == 2'b00 && n < 8) begin @(negedge clk); #1; n++; end
         check("cont_grant", req_ready, (k % 2) ? 2 : 1);
         @(posedge clk);
         @(negedge clk);
         n = 0;
         while (!rsp_valid && n < 8) begin @(negedge clk); n++; end
         check("cont_id", rsp_id, k % 2);
         check("cont_result", rsp_result, (k % 2) ? 4'h5 : 4'h3);
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = '0;

      // Randomized run against the transaction model
      do_reset();
      m_busy = 1'b0; m_ptr = 1'b0; m_cnt = 0; m_saved = '0; m_id = 1'b0;
      m_res = '0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
      m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0; m_alu_f = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [3:0] op, a, b;
         logic       f;
         @(negedge clk);
         if (cyc < 380) begin
            req_valid = 2'($urandom_range(0, 3));
            req_op0 = 4'($urandom_range(0, 15)); req_op1 = 4'($urandom_range(0, 15));
            req_a0 = 4'($urandom); req_a1 = 4'($urandom);
            req_b0 = 4'($urandom); req_b1 = 4'($urandom);
            req_flag0 = 1'($urandom); req_flag1 = 1'($urandom);
            req_chain = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
         end else begin
            req_valid = '0;
            rsp_ready = 1'b1;
         end
         #1;
         win = (req_valid == 2'b11) ? m_ptr : (req_valid == 2'b10);
         exp_rdy = (!m_busy && req_valid != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
         check("rand_ready", req_ready, exp_rdy);
         check("rand_valid", rsp_valid, (m_busy && m_cnt == 0));
         if (m_busy && m_cnt == 0) begin
            check("rand_rsp", {rsp_id, rsp_c, rsp_z, rsp_err, rsp_result},
                  {m_id, m_c, m_z, m_err, m_res});
         end
         check("rand_alu", {alu_a, alu_b, alu_ctrl, alu_flag_in},
               {m_alu_a, m_alu_b, m_alu_ctrl, m_alu_f});
         if (m_busy) begin
            if (m_cnt != 0) m_cnt--;
            else if (rsp_ready) m_busy = 1'b0;
         end else if (req_valid != 2'b00) begin
            op = win ? req_op1 : req_op0;
            a  = win ? req_a1 : req_a0;
            b  = win ? req_b1 : req_b0;
            f  = req_chain[win] ? m_saved[win] : (win ? req_flag1 : req_flag0);
            m_ptr = ~win;
            m_busy = 1'b1;
            m_id = win;
            if (op <= 4'h9) begin
               {m_c, m_z, m_res} = alu_fn(op, a, b, f);
               m_err = 1'b0;
               m_saved[win] = m_c;
               m_alu_a = a; m_alu_b = b; m_alu_ctrl = op; m_alu_f = f;
               m_cnt = 1;
            end else begin
               m_res = '0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b1;
               m_cnt = 0;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
